sram_arbiter: RTL
=================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, giving the number of ACCESS cycles after the first; legal range 1..15.
REQ-002 SHALL have parameter VID_MAX, default 4, giving the maximum consecutive video grants while a CPU request waits; legal range 1..15.
REQ-003 SHALL have port clk_sram, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port vid_req, input, 1 bit: video read request, level, held until vid_ack.
REQ-006 SHALL have port vid_addr, input, 21 bits: video byte address.
REQ-007 SHALL have port vid_ack, output, 1 bit: one-cycle pulse; vid_data is valid in the same cycle.
REQ-008 SHALL have port vid_data, output, 8 bits: registered video read byte.
REQ-009 SHALL have port cpu_req, input, 1 bit: CPU request, level, held until cpu_ack.
REQ-010 SHALL have port cpu_we, input, 1 bit: 1 = write, 0 = read.
REQ-011 SHALL have port cpu_addr, input, 21 bits: CPU byte address.
REQ-012 SHALL have port cpu_wdata, input, 8 bits: CPU write byte.
REQ-013 SHALL have port cpu_ack, output, 1 bit: one-cycle pulse; cpu_rdata is valid in the same cycle for reads.
REQ-014 SHALL have port cpu_rdata, output, 8 bits: registered CPU read byte.
REQ-015 SHALL have port SRAM_ADDR, output, 21 bits: registered SRAM address.
REQ-016 SHALL have port SRAM_DATA_o, output, 8 bits: write data to the pad.
REQ-017 SHALL have port SRAM_DATA_oe, output, 1 bit: pad output enable.
REQ-018 SHALL have port SRAM_DATA_i, input, 8 bits: read data from the pad.
REQ-019 SHALL have port SRAM_WE_n, output, 1 bit: write strobe, active-low.
REQ-020 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-021 SHALL implement states IDLE, ACCESS and DONE; no grant is made in ACCESS or DONE.
REQ-022 In IDLE, SHALL grant video when vid_req=1 and (cpu_req=0 or vid_cnt<VID_MAX); otherwise SHALL grant the CPU when cpu_req=1; otherwise SHALL remain in IDLE.
REQ-023 vid_cnt SHALL increment on a video grant made while cpu_req=1, clear on a CPU grant, and clear in any IDLE cycle with cpu_req=0; it saturates at VID_MAX.
REQ-024 On the grant cycle G, SHALL latch address, cpu_we and cpu_wdata, drive SRAM_ADDR from G+1, and load the wait counter with WAIT_CYCLES.
REQ-025 ACCESS SHALL last cycles G+1..G+1+WAIT_CYCLES; DONE SHALL occupy cycle G+2+WAIT_CYCLES; the FSM returns to IDLE at G+3+WAIT_CYCLES.
REQ-026 Reads: SHALL sample SRAM_DATA_i on the last ACCESS cycle into vid_data or cpu_rdata, and pulse the matching ack in DONE.
REQ-027 Writes: SRAM_DATA_oe=1 through ACCESS and DONE; SRAM_WE_n=1 on the first ACCESS cycle (address setup), 0 on the remaining WAIT_CYCLES ACCESS cycles, and 1 in DONE (data/address hold); cpu_ack pulses in DONE.
REQ-028 SRAM_ADDR SHALL hold its last value in IDLE; SRAM_WE_n=1 and SRAM_DATA_oe=0 in IDLE and for all reads.
REQ-029 Requesters SHALL drop or replace req in the cycle after ack; req is re-evaluated only in IDLE, so a req still high in DONE creates no duplicate grant.
REQ-030 Input changes after the grant cycle SHALL be ignored for the current access.
REQ-031 Withdrawal of an ungranted req SHALL have no side effect other than the vid_cnt rule.
REQ-032 Address 21'h1FFFFF SHALL pass unmodified; there is no address wrap or translation.
REQ-033 At most one ack SHALL be high per cycle; vid_data and cpu_rdata hold their values between acks.

Reset
REQ-034 While rst=1 at a rising edge: state=IDLE, vid_cnt=0, SRAM_ADDR=0, SRAM_DATA_o=0, SRAM_DATA_oe=0, SRAM_WE_n=1, vid_ack=0, cpu_ack=0, vid_data=0, cpu_rdata=0, busy=0.
REQ-035 Reset asserted mid-access SHALL abort the access at that edge: SRAM_WE_n=1 and oe=0 from the next cycle, and no ack is issued for the aborted access.

Verification
REQ-036 Video read, WAIT_CYCLES=1: vid_addr=21'h00ABC with SRAM model data 8'h5A -> SRAM_ADDR=00ABC from G+1, vid_ack at G+3 with vid_data=8'h5A, busy high G+1..G+3.
REQ-037 CPU write, WAIT_CYCLES=2: addr=21'h1FFFFF, data 8'hC3 -> WE_n high at G+1, low at G+2..G+3, high at G+4; oe high G+1..G+4; cpu_ack at G+4; model location 1FFFFF=C3.
REQ-038 Fairness, VID_MAX=4: vid_req and cpu_req held high continuously -> grant order V,V,V,V,C repeating; the CPU waits no more than 4 video accesses.
REQ-039 Simultaneous first requests with vid_cnt=0 -> video is granted first; the CPU is granted in the next IDLE cycle.
REQ-040 rst pulsed during a write at the first WE_n-low cycle -> WE_n=1 and oe=0 on the next cycle, no cpu_ack, model location unchanged.
REQ-041 Back-to-back video reads with req held through ack -> exactly one ack per access, each access WAIT_CYCLES+3 cycles long, no duplicate grant.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-port (video read / CPU read-write) arbiter in front of an async 8-bit SRAM.
// Video wins by default; after VID_MAX back-to-back video grants a waiting CPU gets the next slot.
module sram_arbiter #(
   parameter int WAIT_CYCLES = 1,
   parameter int VID_MAX     = 4
) (
   input  logic        clk_sram,
   input  logic        rst,
   input  logic        vid_req,
   input  logic [20:0] vid_addr,
   output logic        vid_ack,
   output logic [7:0]  vid_data,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [20:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic        cpu_ack,
   output logic [7:0]  cpu_rdata,
   output logic [20:0] SRAM_ADDR,
   output logic [7:0]  SRAM_DATA_o,
   output logic        SRAM_DATA_oe,
   input  logic [7:0]  SRAM_DATA_i,
   output logic        SRAM_WE_n,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t     state;
   logic [3:0] vid_cnt;
   logic [3:0] wait_cnt;
   logic       owner_cpu;
   logic       is_write;
   logic       grant_vid;
   logic       grant_cpu;

   assign grant_vid = vid_req && (!cpu_req || (vid_cnt < 4'(VID_MAX)));
   assign grant_cpu = cpu_req && !grant_vid;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk_sram) begin
      if (rst) begin
         state        <= IDLE;
         vid_cnt      <= '0;
         wait_cnt     <= '0;
         owner_cpu    <= 1'b0;
         is_write     <= 1'b0;
         SRAM_ADDR    <= '0;
         SRAM_DATA_o  <= '0;
         SRAM_DATA_oe <= 1'b0;
         SRAM_WE_n    <= 1'b1;
         vid_ack      <= 1'b0;
         cpu_ack      <= 1'b0;
         vid_data     <= '0;
         cpu_rdata    <= '0;
      end else begin
         vid_ack <= 1'b0;
         cpu_ack <= 1'b0;
         case (state)
            IDLE: begin
               // Count only video grants that made a waiting CPU wait longer.
               if (grant_vid && cpu_req) begin
                  if (vid_cnt != 4'(VID_MAX)) vid_cnt <= vid_cnt + 4'd1;
               end else begin
                  vid_cnt <= '0;
               end
               if (grant_vid || grant_cpu) begin
                  state        <= ACCESS;
                  owner_cpu    <= grant_cpu;
                  is_write     <= grant_cpu && cpu_we;
                  SRAM_ADDR    <= grant_cpu ? cpu_addr : vid_addr;
                  SRAM_DATA_oe <= grant_cpu && cpu_we;
                  SRAM_WE_n    <= 1'b1;
                  wait_cnt     <= 4'(WAIT_CYCLES);
                  if (grant_cpu) SRAM_DATA_o <= cpu_wdata;
               end
            end
            ACCESS: begin
               if (wait_cnt == 4'd0) begin
                  state     <= DONE;
                  SRAM_WE_n <= 1'b1;
                  if (!is_write) begin
                     if (owner_cpu) cpu_rdata <= SRAM_DATA_i;
                     else           vid_data  <= SRAM_DATA_i;
                  end
                  if (owner_cpu) cpu_ack <= 1'b1;
                  else           vid_ack <= 1'b1;
               end else begin
                  // First ACCESS cycle is address setup; strobe low for the rest.
                  wait_cnt  <= wait_cnt - 4'd1;
                  SRAM_WE_n <= !is_write;
               end
            end
            DONE: begin
               state        <= IDLE;
               SRAM_DATA_oe <= 1'b0;
               SRAM_WE_n    <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
